// File: rtl/pa.sv
// Phase accumulator for the DDFS datapath: adds the tuning word to the phase
// register every clock, wrapping modulo 2^NBIT. The register drives the output.
module pa #(
    parameter int NBIT = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBIT-1:0] pa_in,
    output logic [NBIT-1:0] pa_out
);

    logic [NBIT-1:0] acc_r;
    logic [NBIT-1:0] sum_s;

    // Next phase: the carry out of the MSB is dropped, so wrap-around is silent.
    always_comb begin
        sum_s = acc_r + pa_in;
    end

    // Phase register, cleared asynchronously and updated on every rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {NBIT{1'b0}};
        end else begin
            acc_r <= sum_s;
        end
    end

    assign pa_out = acc_r;

endmodule

// File: tb/tb_pa.sv
// Scoreboard bench for pa: a 12-bit and a 24-bit instance share clock and reset;
// expected phases come from running totals of the applied tuning words.
module tb_pa;

    logic        clk;
    logic        rst_n;
    logic [11:0] pa_in12;
    logic [11:0] pa_out12;
    logic [23:0] pa_in24;
    logic [23:0] pa_out24;

    typedef struct {
        logic [11:0] e12;
        logic [23:0] e24;
    } exp_t;

    exp_t              sb[$];
    longint unsigned   tot12;
    longint unsigned   tot24;
    int                n_cmp;
    int                n_bad;

    pa #(.NBIT(12)) dut12 (.clk(clk), .rst_n(rst_n), .pa_in(pa_in12), .pa_out(pa_out12));
    pa #(.NBIT(24)) dut24 (.clk(clk), .rst_n(rst_n), .pa_in(pa_in24), .pa_out(pa_out24));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One clock: apply the tuning words, let the edge happen, record the expected phase.
    task automatic cycle(input logic [11:0] f12, input logic [23:0] f24);
        exp_t e;
        pa_in12 = f12;
        pa_in24 = f24;
        @(posedge clk);
        if (rst_n) begin
            tot12 += 64'(f12);
            tot24 += 64'(f24);
        end else begin
            tot12 = 64'd0;
            tot24 = 64'd0;
        end
        e.e12 = 12'(tot12 % 64'd4096);
        e.e24 = 24'(tot24 % 64'd16777216);
        sb.push_back(e);
        #1;
    endtask

    // Drop reset between edges (after the monitor's sample) and confirm it acts at once.
    task automatic async_reset(input string name);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        tot12 = 64'd0;
        tot24 = 64'd0;
        #1;
        check({name, "_12"}, 32'(pa_out12), 32'd0);
        check({name, "_24"}, 32'(pa_out24), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: the phase is presented every clock, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_phase12", 32'(pa_out12), 32'(e.e12));
                check("sb_phase24", 32'(pa_out24), 32'(e.e24));
            end
        end
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        tot12   = 64'd0;
        tot24   = 64'd0;
        rst_n   = 1'b0;
        pa_in12 = 12'd2;
        pa_in24 = 24'd2;
        #1;
        check("reset_initial", 32'(pa_out12), 32'd0);

        // Reset held across 18 edges
        for (int i = 0; i < 18; i++) begin
            cycle(12'd2, 24'd2);
            check("reset_hold", 32'(pa_out12), 32'd0);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        cycle(12'd2, 24'd2);
        check("first_edge", 32'(pa_out12), 32'd2);
        cycle(12'd2, 24'd2);
        check("second_edge", 32'(pa_out12), 32'd4);

        // Wrap: edge 2047 gives 4094, then 0, then 2
        for (int n = 3; n <= 2047; n++) cycle(12'd2, 24'd2);
        check("pre_wrap", 32'(pa_out12), 32'd4094);
        check("no_wrap24", 32'(pa_out24), 32'd4094);
        cycle(12'd2, 24'd2);
        check("wrap_zero", 32'(pa_out12), 32'd0);
        check("carry24", 32'(pa_out24), 32'd4096);
        cycle(12'd2, 24'd2);
        check("wrap_two", 32'(pa_out12), 32'd2);

        // Negative step: all-ones word decrements by one
        async_reset("reset_neg");
        cycle(12'd4095, 24'hFFFFFF);
        check("neg_1", 32'(pa_out12), 32'd4095);
        cycle(12'd4095, 24'hFFFFFF);
        check("neg_2", 32'(pa_out12), 32'd4094);
        cycle(12'd4095, 24'hFFFFFF);
        check("neg_3", 32'(pa_out12), 32'd4093);
        check("neg_3_24", 32'(pa_out24), 32'hFFFFFD);

        // Tuning change and hold
        async_reset("reset_tune");
        for (int i = 0; i < 5; i++) cycle(12'd2, 24'd2);
        check("count_ten", 32'(pa_out12), 32'd10);
        cycle(12'd100, 24'd100);
        check("tune_110", 32'(pa_out12), 32'd110);
        pa_in12 = 12'd7;
        pa_in24 = 24'd7;
        #1;
        check("no_comb_path", 32'(pa_out12), 32'd110);
        cycle(12'd0, 24'd0);
        check("hold_1", 32'(pa_out12), 32'd110);
        cycle(12'd0, 24'd0);
        check("hold_2", 32'(pa_out12), 32'd110);

        // Async reset mid-run, restart with step 5
        async_reset("reset_mid");
        cycle(12'd5, 24'd5);
        check("restart_5", 32'(pa_out12), 32'd5);
        cycle(12'd5, 24'd5);
        check("restart_10", 32'(pa_out12), 32'd10);
        cycle(12'd5, 24'd5);
        check("restart_15", 32'(pa_out12), 32'd15);

        // Random tuning words, changed on random cycles, including holds
        begin
            logic [11:0] f12;
            logic [23:0] f24;
            f12 = 12'd1;
            f24 = 24'd1;
            for (int i = 0; i < 10000; i++) begin
                case ($urandom_range(0, 7))
                    0:       begin f12 = 12'($urandom); f24 = 24'($urandom); end
                    1:       begin f12 = 12'd0;         f24 = 24'd0;         end
                    2:       begin f12 = 12'hFFF;       f24 = 24'($urandom); end
                    default: begin end
                endcase
                cycle(f12, f24);
            end
        end

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pa.md
# pa

Phase accumulator for the DDFS datapath. Every clock it adds an NBIT-bit frequency tuning word to an NBIT-bit phase register, wrapping modulo 2^NBIT. The phase register value is the output, and it feeds the phase-to-amplitude (sine LUT) stage downstream.

## Interface
Parameters:
- NBIT, default 12: width of the tuning word, the accumulator and the output phase. Legal range is 2..32.

Ports:
- clk  input  1: single system clock. All state updates on its rising edge.
- rst_n  input  1: reset, asynchronous, active-low. Asserting it clears the accumulator immediately. Release is sampled on clk.
- pa_in  input  NBIT: frequency tuning word (phase increment per clock), unsigned.
- pa_out  output  NBIT: current accumulated phase, unsigned, driven directly from the phase register.

## Operation
- State is one NBIT-bit register `acc`, and pa_out = acc.
- While rst_n = 0, acc = 0 regardless of clk or pa_in.
- On each rising clk edge with rst_n = 1: acc <= (acc + pa_in) mod 2^NBIT.
- The carry out of the MSB is discarded. Wrap-around is silent, with no overflow flag.
- pa_in is treated as unsigned. A value of 2^NBIT − k behaves as a decrement by k per clock.
- pa_in = 0 holds acc constant.
- pa_in is sampled at each rising edge with no input register. A change takes effect on the very next edge.
- Output frequency = f_clk · pa_in / 2^NBIT.
- There are no enables or handshakes. The accumulator runs on every clock out of reset.

## Timing
- Reset value of pa_out: 0. It is asserted asynchronously, within the same delta or time step as rst_n falling, with no clock edge needed.
- Reset held low across clock edges: pa_out stays 0.
- First rising edge with rst_n = 1: pa_out = pa_in (0 + pa_in).
- Edge n after reset release, with constant pa_in = F: pa_out = n·F mod 2^NBIT.
- Latency from a pa_in change to its effect on pa_out is one clock (one registered add).
- Reset asserted mid-count: pa_out goes to 0 at once. Counting restarts from 0 on the first edge after release.
- The path pa_in → acc is a single NBIT-bit adder plus register, and there is no combinational path from pa_in to pa_out.

## Test plan
1. Reset: NBIT = 12, pa_in = 2, rst_n = 0 for 18 clocks -> pa_out = 0 throughout. Release -> pa_out reads 2, 4, 6, ... on successive rising edges.
2. Wrap: NBIT = 12, pa_in = 2, run 2048 edges after release -> pa_out reaches 4094, then 0, then 2, with no glitch or stall.
3. Negative step: pa_in = 4095 (12-bit) -> pa_out reads 4095, 4094, 4093, ... (decrement by 1 mod 4096).
4. Tuning change and hold: count at pa_in = 2 to pa_out = 10, set pa_in = 100 -> next edge 110. Set pa_in = 0 -> pa_out holds 110.
5. Async reset mid-run: at pa_out = 110, drop rst_n between clock edges -> pa_out = 0 immediately, before any edge. Release with pa_in = 5 -> 5, 10, 15.
6. Reference-model check: random pa_in changes over 10,000 cycles for NBIT = 12 and NBIT = 24 -> pa_out equals the software model acc = (acc + pa_in) mod 2^NBIT every cycle.
